// File: rtl/reflow_track_if.sv
// reflow_track_if: decode-side bus between the decode stage and the reflow_track forwarding tracker
interface reflow_track_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     flush;
  logic                     push_valid;
  logic                     push_wen;
  logic [ADDR_W-1:0]        push_addr;
  logic                     push_pending;
  logic [DATA_W-1:0]        push_data;
  logic                     fill_valid;
  logic [DATA_W-1:0]        fill_data;
  logic [NUM_RD-1:0]        rd_used;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_rf_data;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     stall;
  logic                     err;
  modport master (
    output flush, push_valid, push_wen, push_addr, push_pending, push_data,
    output fill_valid, fill_data, rd_used, rd_addr, rd_rf_data,
    input  rd_data, stall, err
  );
  modport slave (
    input  flush, push_valid, push_wen, push_addr, push_pending, push_data,
    input  fill_valid, fill_data, rd_used, rd_addr, rd_rf_data,
    output rd_data, stall, err
  );
endinterface

// File: rtl/reflow_track.sv
// reflow_track: in-flight write tracker with youngest-wins forwarding and load-use stall; REFLOW_TRACK_PERF_EN adds a stall_cycles counter
module reflow_track #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2
) (
  input logic           clk,
  input logic           rst_n,
  reflow_track_if.slave bus
`ifdef REFLOW_TRACK_PERF_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);
  logic [DEPTH-1:0]  vld_q, vld_d, wen_q, wen_d, pend_q, pend_d;
  logic [DEPTH-1:0]  cand, fill_sel;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              err_q, err_d, fill_any;
  logic [NUM_RD-1:0] blocked;
  logic              hit, hpend, htgt;
  logic [DATA_W-1:0] hdata;
  logic [ADDR_W-1:0] ra;
  // fill goes to the oldest pending write; fill_any also flags a fill with nothing to land on
  always_comb begin
    fill_any = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      cand[k]     = vld_q[k] & wen_q[k] & pend_q[k];
      fill_sel[k] = cand[k] & ~fill_any & bus.fill_valid;
      fill_any    = fill_any | cand[k];
    end
  end
  always_comb begin
    vld_d[0]  = bus.push_valid & ~bus.flush;
    wen_d[0]  = bus.push_wen;
    addr_d[0] = bus.push_addr;
    pend_d[0] = bus.push_pending;
    data_d[0] = bus.push_data;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1] & ~bus.flush;
      wen_d[k]  = wen_q[k-1];
      addr_d[k] = addr_q[k-1];
      pend_d[k] = pend_q[k-1] & ~fill_sel[k-1];
      data_d[k] = fill_sel[k-1] ? bus.fill_data : data_q[k-1];
    end
    err_d = err_q | (~bus.flush & ((cand[DEPTH-1] & ~fill_sel[DEPTH-1]) |
                                   (bus.fill_valid & ~fill_any)));
  end
  // scanning oldest to youngest lets the youngest match overwrite the result
  always_comb begin
    bus.rd_data = bus.rd_rf_data;
    blocked     = '0;
    ra          = '0;
    hit         = 1'b0;
    hpend       = 1'b0;
    htgt        = 1'b0;
    hdata       = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      hit   = 1'b0;
      hpend = 1'b0;
      htgt  = 1'b0;
      hdata = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (vld_q[k] && wen_q[k] && addr_q[k] == ra) begin
          hit   = 1'b1;
          hpend = pend_q[k];
          htgt  = fill_sel[k];
          hdata = data_q[k];
        end
      end
      if (hit && ra != '0) begin
        if (!hpend) bus.rd_data[i*DATA_W +: DATA_W] = hdata;
        else if (htgt) bus.rd_data[i*DATA_W +: DATA_W] = bus.fill_data;
        else blocked[i] = 1'b1;
      end
    end
  end
  assign bus.stall = |(blocked & bus.rd_used);
  assign bus.err   = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wen_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      wen_q  <= wen_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
`ifdef REFLOW_TRACK_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  always_comb stall_cycles_d = (bus.stall && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_reflow_track.sv
// tb_reflow_track: randomized and directed checks of reflow_track against a per-entry behavioural model
module tb_reflow_track;
  localparam int DW = 32, AW = 5, D = 3, NR = 2;
  typedef struct {
    bit            vld;
    bit            wen;
    bit [AW-1:0]   addr;
    bit            pend;
    bit [DW-1:0]   data;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int   n_vec = 0, n_err = 0;
  ent_t m [D];
  bit   m_err = 1'b0;
  reflow_track_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
`ifdef REFLOW_TRACK_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] sc = '0;
`endif
  reflow_track #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_RD(NR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef REFLOW_TRACK_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ftgt();
    int t = -1;
    for (int k = 0; k < D; k++) if (m[k].vld && m[k].wen && m[k].pend) t = k;
    return t;
  endfunction

  task automatic model_port(input int i, output logic [DW-1:0] d, output bit blk);
    logic [AW-1:0] a = bus.rd_addr[i*AW +: AW];
    int y = -1;
    for (int k = D - 1; k >= 0; k--) if (m[k].vld && m[k].wen && m[k].addr == a) y = k;
    d   = bus.rd_rf_data[i*DW +: DW];
    blk = 1'b0;
    if (a != 0 && y >= 0) begin
      if (!m[y].pend) d = m[y].data;
      else if (bus.fill_valid && y == ftgt()) d = bus.fill_data;
      else blk = 1'b1;
    end
  endtask

  task automatic model_edge(input bit est);
    int t = ftgt();
`ifdef REFLOW_TRACK_PERF_EN
    if (est && sc != 16'hFFFF) sc++;
`endif
    if (bus.flush) begin
      for (int k = 0; k < D; k++) m[k].vld = 1'b0;
      return;
    end
    if (bus.fill_valid) begin
      if (t < 0) m_err = 1'b1;
      else begin
        m[t].pend = 1'b0;
        m[t].data = bus.fill_data;
      end
    end
    if (m[D-1].vld && m[D-1].wen && m[D-1].pend) m_err = 1'b1;
    for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
    m[0] = '{bus.push_valid, bus.push_wen, bus.push_addr, bus.push_pending, bus.push_data};
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) m[k].vld = 1'b0;
    m_err = 1'b0;
`ifdef REFLOW_TRACK_PERF_EN
    sc = '0;
`endif
  endtask

  task automatic cycle();
    logic [DW-1:0] ed;
    bit blk, est;
    @(negedge clk);
    est = 1'b0;
    for (int i = 0; i < NR; i++) begin
      model_port(i, ed, blk);
      if (!blk) chk($sformatf("rd_data%0d", i), bus.rd_data[i*DW +: DW], ed);
      est |= blk & bus.rd_used[i];
    end
    chk("stall", 32'(bus.stall), 32'(est));
    chk("err", 32'(bus.err), 32'(m_err));
`ifdef REFLOW_TRACK_PERF_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(sc));
`endif
    @(posedge clk);
    model_edge(est);
    #1;
  endtask

  task automatic idle();
    bus.push_valid = 1'b0;
    bus.fill_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic p, input logic [DW-1:0] d);
    bus.push_valid   = 1'b1;
    bus.push_wen     = 1'b1;
    bus.push_addr    = a;
    bus.push_pending = p;
    bus.push_data    = d;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] u);
    bus.rd_addr    = {a1, a0};
    bus.rd_used    = u;
    bus.rd_rf_data = {$urandom, $urandom};
  endtask

  // entered just after a rising edge; the edge following release is idle
  task automatic reset_dut();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rd0", bus.rd_data[DW-1:0], bus.rd_rf_data[DW-1:0]);
    chk("rst_rd1", bus.rd_data[2*DW-1:DW], bus.rd_rf_data[2*DW-1:DW]);
`ifdef REFLOW_TRACK_PERF_EN
    chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0);
    #1;
  endtask

  initial begin
    idle();
    push(0, 0, 0);
    bus.push_valid = 1'b0;
    bus.fill_data  = '0;
    rd(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
    cycle();
    // forward then retire
    push(5, 0, 32'h11);
    cycle();
    idle();
    rd(5, 0, 2'b11);
    #1 chk("fwd5", bus.rd_data[DW-1:0], 32'h11);
    repeat (D + 1) cycle();
    // youngest wins; address 0 never forwarded
    push(7, 0, 32'hA);
    cycle();
    push(7, 0, 32'hB);
    cycle();
    push(0, 0, 32'hDEAD);
    rd(7, 0, 2'b11);
    #1 chk("youngest7", bus.rd_data[DW-1:0], 32'hB);
    cycle();
    idle();
    rd(0, 7, 2'b11);
    #1 chk("addr0", bus.rd_data[DW-1:0], bus.rd_rf_data[DW-1:0]);
    cycle();
    // load-use stall and same-cycle fill bypass
    push(3, 1, 0);
    cycle();
    idle();
    rd(3, 3, 2'b01);
    #1 chk("lu_stall", 32'(bus.stall), 32'd1);
    bus.fill_valid = 1'b1;
    bus.fill_data  = 32'h55;
    #1 chk("fill_nostall", 32'(bus.stall), 32'd0);
    chk("fill_bypass", bus.rd_data[DW-1:0], 32'h55);
    cycle();
    idle();
    #1 chk("filled", bus.rd_data[DW-1:0], 32'h55);
    repeat (D + 1) cycle();
    // unfilled retirement sets sticky err
    push(3, 1, 0);
    rd(3, 3, 2'b00);
    cycle();
    idle();
    repeat (D + 1) cycle();
    chk("err_retire", 32'(bus.err), 32'd1);
    reset_dut();
    bus.fill_valid = 1'b1;
    cycle();
    idle();
    cycle();
    chk("err_fill_empty", 32'(bus.err), 32'd1);
    reset_dut();
    // flush drops entries and the simultaneous push
    push(1, 0, 1);
    cycle();
    push(2, 1, 2);
    cycle();
    push(4, 0, 4);
    cycle();
    push(1, 0, 9);
    bus.flush = 1'b1;
    rd(1, 2, 2'b11);
    cycle();
    idle();
    rd(1, 4, 2'b11);
    #1 chk("flush_rd0", bus.rd_data[DW-1:0], bus.rd_rf_data[DW-1:0]);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    cycle();
    // stall held over several cycles, then reset mid-stall
    push(6, 1, 0);
    rd(6, 6, 2'b11);
    cycle();
    push(6, 1, 0);
    cycle();
    idle();
    repeat (2) cycle();
    reset_dut();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) reset_dut();
      bus.push_valid   = $urandom_range(0, 2) != 0;
      bus.push_wen     = $urandom_range(0, 3) != 0;
      bus.push_addr    = AW'($urandom_range(0, 3));
      bus.push_pending = $urandom_range(0, 2) == 0;
      bus.push_data    = $urandom;
      bus.fill_valid   = $urandom_range(0, 3) == 0;
      bus.fill_data    = $urandom;
      bus.flush        = $urandom_range(0, 19) == 0;
      rd(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 2'($urandom));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reflow_track.md
Name: reflow_track

Overview:
- Parametrised successor to the dual/single combinational forwarding muxes.
- Owns a DEPTH-entry shift register of in-flight register writes (EX→WB) and forwards the youngest matching write to NUM_RD decode read ports.
- Tracks pending (late, e.g. load) results, accepts their data through a fill port, and raises a load-use stall when a read hits a still-pending write.
- Sits between the decode stage and the register file.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; address 0 never forwarded
DEPTH, 3, in-flight entries tracked (stage 0 youngest, DEPTH-1 oldest/retiring); legal 1..8
NUM_RD, 2, decode read ports

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all in-flight entries
push_valid  in  1  new write record enters stage 0 this cycle
push_wen  in  1  record writes a register
push_addr  in  ADDR_W  destination register
push_pending  in  1  data not yet known (load)
push_data  in  DATA_W  result when !push_pending
fill_valid  in  1  late result available
fill_data  in  DATA_W  late result value
rd_used  in  NUM_RD  per-port: operand actually consumed
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_rf_data  in  NUM_RD*DATA_W  register-file read data
rd_data  out  NUM_RD*DATA_W  forwarded operands
stall  out  1  load-use stall request to decode
err  out  1  sticky: pending entry retired unfilled, or fill with nothing pending

Behaviour:
- Entry fields: vld, wen, addr, pend, data.
- Reset: all vld=0, err=0; rd_data = rd_rf_data and stall=0 combinationally.
- Every rising edge the register shifts by one:
  - stage k+1 ← stage k.
  - stage 0 ← push record if push_valid, else bubble (vld=0).
  - Stage DEPTH-1 contents drop out; the regfile is assumed written by then.
- Fill:
  - fill_valid targets the oldest entry (highest stage) with vld&wen&pend, evaluated before the shift.
  - Its data ← fill_data and pend ← 0, and the result moves with the shift.
- A push with push_pending=1 and a same-cycle fill_valid does not consume the fill; the fill targets existing entries only.
- Forwarding, per port i, combinational:
  - Select the lowest-index stage with vld&wen&addr==rd_addr[i].
  - If none, or rd_addr[i]==0: rd_data[i] = rd_rf_data[i].
  - If the match is not pending: rd_data[i] = entry data.
  - If the match is pending and it is the fill target with fill_valid=1: rd_data[i] = fill_data (same-cycle bypass, no stall).
  - Otherwise the port is blocked.
- stall = OR over i of (rd_used[i] & port blocked). No registered latency; forwarding is zero-cycle.
- Flush:
  - Next edge clears every vld, including the simultaneous push; any fill that cycle is discarded without setting err.
  - Combinational outputs during the flush cycle still reflect the current contents.
- err sets, if not flushing:
  - at an edge where stage DEPTH-1 holds vld&wen&pend and is not filled that cycle, or
  - at fill_valid with no pending entry.
  - err clears only on reset.
- Multiple matches: the youngest always wins; an older pending match never stalls if a younger non-pending match exists.
- Async reset mid-operation clears all state immediately; outputs revert to pass-through.

Optional Feature:
- Macro REFLOW_TRACK_PERF_EN. When defined, add output stall_cycles[15:0]:
  - increments each edge with stall=1, saturates at 16'hFFFF, clears on reset.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Push {wen=1,addr=5,data=0x11}; next cycle read addr 5 → rd_data=0x11, stall=0; after DEPTH further cycles → rd_rf_data.
- Push addr 7 data 0xA then addr 7 data 0xB; read addr 7 → 0xB (youngest wins); read addr 0 with a matching addr-0 push → rf data.
- Push pending addr 3, rd_used=1, read addr 3 → stall=1; assert fill_valid,fill_data=0x55 same cycle → stall=0, rd_data=0x55; next cycle entry non-pending with 0x55.
- Pending addr 3 with rd_used=0 → stall=0; never filled for DEPTH cycles → err=1 persistently; fill_valid with empty tracker → err=1.
- Three entries in flight, flush=1 with push_valid=1 → next cycle all reads pass through, stall=0, err unchanged.
- With REFLOW_TRACK_PERF_EN: hold a load-use stall 4 cycles → stall_cycles=4; reset mid-stall → stall_cycles=0, stall=0 immediately.
